// File: rtl/down_timer.sv
// down_timer: loadable N-bit down-counting timer with one-shot and auto-reload modes.
// Define DOWN_TIMER_PRESCALE_EN to advance the count only once every PRESC clocks.
module down_timer #(
  parameter int N     = 4,
  parameter int PRESC = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         auto_reload,
  input  logic         stop,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         zero
);

  // Handshake: start (with load_val/auto_reload) is accepted only in IDLE and
  // stop only in RUN; start beats stop in IDLE; done is a single-cycle pulse.
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_n;
  logic [N-1:0] q_n;
  logic [N-1:0] reload_reg, reload_n;
  logic         mode_reg, mode_n;
  logic         busy_n, done_n;
  logic         presc_clr;
  logic         tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESC);

  logic [PW-1:0] presc_cnt;

  assign tick = (presc_cnt == PW'(PRESC - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      presc_cnt <= '0;
    else if (presc_clr)
      presc_cnt <= '0;
    else if (state == RUN)
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
  end
`else
  // Without the prescaler every edge is a tick (PRESC is always >= 2).
  assign tick = (PRESC != 0);
`endif

  always_comb begin
    state_n   = state;
    q_n       = q;
    reload_n  = reload_reg;
    mode_n    = mode_reg;
    busy_n    = busy;
    done_n    = 1'b0;
    presc_clr = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (load_val != '0) begin
            q_n       = load_val;
            reload_n  = load_val;
            mode_n    = auto_reload;
            busy_n    = 1'b1;
            state_n   = RUN;
            presc_clr = 1'b1;
          end else begin
            q_n    = '0;
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          busy_n    = 1'b0;
          state_n   = IDLE;
          presc_clr = 1'b1;
        end else if (tick) begin
          if (q > N'(1)) begin
            q_n = q - N'(1);
          end else if (!mode_reg) begin
            q_n       = '0;
            done_n    = 1'b1;
            busy_n    = 1'b0;
            state_n   = IDLE;
            presc_clr = 1'b1;
          end else begin
            q_n    = reload_reg;
            done_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      reload_reg <= reload_n;
      mode_reg   <= mode_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  assign zero = (q == '0);

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable N-bit down-counting timer with a start/stop/done handshake.
- Counts the opposite direction from the team's free-running up-counter.
- Used to generate timeouts and periodic ticks for the neighbouring control logic.
- Supports one-shot and auto-reload modes.

Parameters:
- N, 4, width of the count register and of load_val.
- PRESC, 4, prescaler divide ratio, only used when PRESCALE_EN is defined; legal range is 2 to 2^16.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset; asynchronous, active-high; clock clk.
- start  input  1  request to load load_val and begin counting; sampled in IDLE only.
- load_val  input  N  initial (and reload) count; sampled together with start.
- auto_reload  input  1  mode select, sampled together with start; 1 = periodic, 0 = one-shot.
- stop  input  1  abort request; sampled in RUN only.
- q  output  N  current count value (registered).
- busy  output  1  high while in RUN (registered).
- done  output  1  one-cycle pulse on terminal count (registered).
- zero  output  1  combinational, equal to (q == 0).

Behaviour:
- Reset (clr high, any time, asynchronous):
  - state = IDLE; q = 0; busy = 0; done = 0.
  - Latched reload value and mode are cleared to 0.
  - Reset mid-count aborts the count with no done pulse.
- States: IDLE, RUN. Encoding is free.
- IDLE, start = 1 and load_val != 0, at the edge:
  - q <= load_val; reload_reg <= load_val; mode_reg <= auto_reload.
  - busy <= 1; go to RUN.
- IDLE, start = 1 and load_val == 0:
  - done <= 1 for one cycle; q <= 0; stay in IDLE; busy stays 0.
- IDLE, start = 0: q holds its value; stop is ignored.
- RUN, every edge (every tick when PRESCALE_EN is defined):
  - stop = 1 has highest priority: go to IDLE, busy <= 0, q holds its current value, no done pulse.
  - Otherwise, if q > 1: q <= q - 1.
  - Otherwise, if q == 1 and mode_reg = 0: q <= 0; done <= 1; busy <= 0; go to IDLE.
  - Otherwise, if q == 1 and mode_reg = 1: q <= reload_reg; done <= 1; stay in RUN.
- done is high for exactly one clk cycle per terminal count and is low in every other cycle.
- start is ignored while in RUN; load_val and auto_reload may change during RUN without effect.
- Timing:
  - One-shot: done is first high L clock cycles after the cycle in which q first shows L (L = load_val); it coincides with q == 0.
  - Auto-reload: done pulses every L cycles, coinciding with q == L.
  - Minimum period is 1 (L = 1): done is high on every cycle in auto-reload mode.
- Arithmetic is unsigned N-bit. q never wraps below 0; the value 2^N-1 is a legal load.
- start and stop high in the same IDLE cycle: start wins.
- The cycle after a one-shot done, the block is back in IDLE and accepts a new start.

Optional Feature:
- Macro: DOWN_TIMER_PRESCALE_EN.
- Defined:
  - An internal prescaler counter counts 0 .. PRESC-1 while in RUN and generates tick when it wraps to 0.
  - q changes only on tick; stop is still honoured on any edge.
  - The prescaler clears on start accept, on stop, on one-shot terminal count and on clr.
  - One-shot done arrives L*PRESC cycles after load.
- Not defined:
  - There is no prescaler logic; tick is constant 1; behaviour is exactly as above; the PRESC parameter is unused.

Test Plan:
- Reset: assert clr asynchronously mid-RUN with q = 5 -> q = 0, busy = 0, done = 0 immediately; no done pulse after release.
- One-shot: load_val = 4, auto_reload = 0, start pulse -> q sequence 4, 3, 2, 1, 0; done high only in the q = 0 cycle; busy falls in that same cycle; zero = 1 afterwards.
- Auto-reload: load_val = 3, auto_reload = 1 -> q sequence 3, 2, 1, 3, 2, 1, 3, ...; done pulses every 3 cycles when q = 3 after reload; busy stays 1.
- Stop: load_val = 15, stop asserted when q = 9 -> IDLE, q holds 9, busy = 0, no done; start ignored while in RUN, verified by pulsing start at q = 12 with load_val = 2.
- Boundaries:
  - start with load_val = 0 -> single done pulse, busy stays 0.
  - load_val = 1 in auto-reload -> done high on every cycle.
  - load_val = 15 with N = 4 -> 15 decrements with no wrap.
- Prescale (macro defined, PRESC = 4): load_val = 2 one-shot -> q holds each value for 4 cycles; done arrives 8 cycles after q = 2 appears.
